rxpybitp: RTL and testbench

// Receive-side payload bit processor, counterpart of the TX payload sequencer. Takes demodulated payload

---
 rtl/rxpybitp.sv | 223 ++++++++++++++++++++++
 tb/tb_rxpybitp.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rxpybitp.sv
// rtl/rxpybitp.sv - RX payload bit processor: de-whitening, FEC 2/3 decode, CRC16 check, FHS capture
module rxpybitp #(
    parameter int LEN_W = 13,
    parameter int CNT_W = 8
) (
    input  logic               clk_6M,
    input  logic               rst,
    input  logic               py_st_p,
    input  logic               rxbit,
    input  logic               rxbit_valid_p,
    input  logic [LEN_W-1:0]   pylenbit,
    input  logic               crcencode,
    input  logic               fec32encode,
    input  logic [6:0]         whitening,
    input  logic [7:0]         crc_init_uap,
    input  logic               fhs_capture,
    output logic               py_period,
    output logic               rxpy_bit,
    output logic               rxpy_valid_p,
    output logic [LEN_W-1:0]   rxpy_bitcount,
    output logic               py_endp,
    output logic               crc_ok,
    output logic [CNT_W-1:0]   fec_corr_cnt,
    output logic               fec_uncorr,
    output logic [143:0]       fhs_data
);

    // One extra bit so pylenbit plus the 16 CRC bits (and coded counts) cannot wrap.
    localparam int CW = LEN_W + 1;
    localparam logic [5:0] FEC_G = 6'b110101;

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DRAIN, S_DONE} state_t;

    state_t           r_state;
    logic [LEN_W-1:0] r_pylen;
    logic             r_crcen;
    logic             r_fecen;
    logic             r_fhscap;
    logic [CW-1:0]    r_codlen;
    logic [CW-1:0]    r_ccnt;
    logic [CW-1:0]    r_dcnt;
    logic [3:0]       r_bpos;
    logic [13:0]      r_sr;
    logic [8:0]       r_hold;
    logic [3:0]       r_left;
    logic [6:0]       r_wlfsr;
    logic [15:0]      r_crc;
    logic [CW-1:0]    r_kidx;

    logic             w_acc;
    logic             w_dw;
    logic [14:0]      w_blk;
    logic             w_blk_done;
    logic [4:0]       w_syn;
    logic             w_corr;
    logic             w_uncorr;
    logic [9:0]       w_fdata;
    logic             w_em_valid;
    logic             w_em_bit;
    logic             w_last_bit;
    logic             w_crc_fb;
    logic [15:0]      w_crc_nxt;
    logic [6:0]       w_lfsr_nxt;
    logic             w_k_data;
    logic             w_k_crc;
    logic             w_start;
    logic [CW-1:0]    w_len;

    // Bit i of the block is the coefficient of D^i; the first received bit is D^14.
    function automatic logic [4:0] f_syn(input logic [14:0] v);
        logic [14:0] t;
        t = v;
        for (int i = 14; i >= 5; i--) begin
            if (t[i]) t = t ^ (15'(FEC_G) << (i - 5));
        end
        return t[4:0];
    endfunction

    assign w_acc      = (r_state == S_RECV) && rxbit_valid_p;
    assign w_dw       = rxbit ^ r_wlfsr[6];
    assign w_blk      = {r_sr, w_dw};
    assign w_blk_done = w_acc && r_fecen && (r_bpos == 4'd14);
    assign w_syn      = f_syn(w_blk);
    assign w_uncorr   = (w_syn != 5'd0) && !w_corr;
    assign w_lfsr_nxt = {r_wlfsr[5:4], r_wlfsr[3] ^ r_wlfsr[6], r_wlfsr[2:0], r_wlfsr[6]};
    assign w_crc_fb   = r_crc[15] ^ w_em_bit;
    assign w_crc_nxt  = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);
    assign w_k_data   = r_kidx < {1'b0, r_pylen};
    assign w_k_crc    = r_kidx < r_codlen;
    assign w_start    = py_st_p && (pylenbit != '0);
    assign w_len      = {1'b0, pylenbit} + (crcencode ? CW'(16) : CW'(0));

    always_comb begin
        w_corr  = 1'b0;
        w_fdata = '0;
        for (int p = 0; p < 15; p++) begin
            if (w_syn == f_syn(15'(1) << p)) w_corr = 1'b1;
        end
        for (int j = 0; j < 10; j++) begin
            w_fdata[j] = w_blk[14-j] ^ (w_syn == f_syn(15'(1) << (14 - j)));
        end
    end

    // Bit 0 of a fresh block goes straight out; bits 1..9 follow from the holding register.
    always_comb begin
        w_em_valid = 1'b0;
        w_em_bit   = 1'b0;
        if (!r_fecen) begin
            w_em_valid = w_acc;
            w_em_bit   = w_dw;
        end else if (r_left != 4'd0) begin
            w_em_valid = 1'b1;
            w_em_bit   = r_hold[0];
        end else if (w_blk_done) begin
            w_em_valid = 1'b1;
            w_em_bit   = w_fdata[0];
        end
    end

    assign w_last_bit = r_fecen ? (w_blk_done && ((r_dcnt + CW'(10)) >= r_codlen))
                                : (w_acc && (r_ccnt == r_codlen - CW'(1)));

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pylen       <= '0;
            r_crcen       <= 1'b0;
            r_fecen       <= 1'b0;
            r_fhscap      <= 1'b0;
            r_codlen      <= '0;
            r_ccnt        <= '0;
            r_dcnt        <= '0;
            r_bpos        <= '0;
            r_sr          <= '0;
            r_hold        <= '0;
            r_left        <= '0;
            r_wlfsr       <= '0;
            r_crc         <= '0;
            r_kidx        <= '0;
            py_period     <= 1'b0;
            rxpy_bit      <= 1'b0;
            rxpy_valid_p  <= 1'b0;
            rxpy_bitcount <= '0;
            py_endp       <= 1'b0;
            crc_ok        <= 1'b0;
            fec_corr_cnt  <= '0;
            fec_uncorr    <= 1'b0;
            fhs_data      <= '0;
        end else if (py_st_p && (r_state != S_IDLE || pylenbit != '0)) begin
            // Start or abort-and-restart; a zero-length start while busy just aborts.
            r_state       <= w_start ? S_RECV : S_IDLE;
            py_period     <= w_start;
            r_pylen       <= pylenbit;
            r_crcen       <= crcencode;
            r_fecen       <= fec32encode;
            r_fhscap      <= fhs_capture;
            r_codlen      <= w_len;
            r_ccnt        <= '0;
            r_dcnt        <= '0;
            r_bpos        <= '0;
            r_sr          <= '0;
            r_hold        <= '0;
            r_left        <= '0;
            r_wlfsr       <= whitening;
            r_crc         <= {8'h00, crc_init_uap};
            r_kidx        <= '0;
            rxpy_bit      <= 1'b0;
            rxpy_valid_p  <= 1'b0;
            rxpy_bitcount <= '0;
            py_endp       <= 1'b0;
            crc_ok        <= 1'b0;
            fec_corr_cnt  <= '0;
            fec_uncorr    <= 1'b0;
        end else begin
            rxpy_valid_p <= 1'b0;
            py_endp      <= 1'b0;
            if (w_acc) begin
                r_wlfsr <= w_lfsr_nxt;
                r_ccnt  <= r_ccnt + CW'(1);
                if (r_fecen) begin
                    r_sr   <= w_blk[13:0];
                    r_bpos <= (r_bpos == 4'd14) ? 4'd0 : r_bpos + 4'd1;
                end
            end
            if (w_blk_done) begin
                r_dcnt <= r_dcnt + CW'(10);
                r_hold <= w_fdata[9:1];
                r_left <= 4'd9;
                if (w_corr && fec_corr_cnt != '1) fec_corr_cnt <= fec_corr_cnt + CNT_W'(1);
                if (w_uncorr) fec_uncorr <= 1'b1;
            end else if (r_left != 4'd0) begin
                r_hold <= {1'b0, r_hold[8:1]};
                r_left <= r_left - 4'd1;
            end
            if (w_em_valid) begin
                r_kidx <= r_kidx + CW'(1);
                if (w_k_crc) r_crc <= w_crc_nxt;
                if (w_k_data) begin
                    rxpy_valid_p  <= 1'b1;
                    rxpy_bit      <= w_em_bit;
                    rxpy_bitcount <= r_kidx[LEN_W-1:0];
                    if (r_fhscap && r_kidx < CW'(144)) fhs_data[r_kidx[7:0]] <= w_em_bit;
                end
            end
            case (r_state)
                S_RECV: if (w_last_bit) r_state <= S_DRAIN;
                S_DRAIN: begin
                    if (r_left == 4'd0) begin
                        r_state <= S_DONE;
                        py_endp <= 1'b1;
                        crc_ok  <= !r_crcen || (r_crc == 16'h0000);
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    py_period <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rxpybitp.sv
// tb/tb_rxpybitp.sv - randomized self-checking bench for rxpybitp against a packet-level model
module tb_rxpybitp;

    localparam int LEN_W = 13;
    localparam int CNT_W = 8;

    logic               clk_6M = 1'b0;
    logic               rst = 1'b1;
    logic               py_st_p = 1'b0;
    logic               rxbit = 1'b0;
    logic               rxbit_valid_p = 1'b0;
    logic [LEN_W-1:0]   pylenbit = '0;
    logic               crcencode = 1'b0;
    logic               fec32encode = 1'b0;
    logic [6:0]         whitening = '0;
    logic [7:0]         crc_init_uap = '0;
    logic               fhs_capture = 1'b0;
    logic               py_period;
    logic               rxpy_bit;
    logic               rxpy_valid_p;
    logic [LEN_W-1:0]   rxpy_bitcount;
    logic               py_endp;
    logic               crc_ok;
    logic [CNT_W-1:0]   fec_corr_cnt;
    logic               fec_uncorr;
    logic [143:0]       fhs_data;

    always #5 clk_6M = ~clk_6M;

    rxpybitp #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk_6M(clk_6M), .rst(rst), .py_st_p(py_st_p), .rxbit(rxbit),
        .rxbit_valid_p(rxbit_valid_p), .pylenbit(pylenbit), .crcencode(crcencode),
        .fec32encode(fec32encode), .whitening(whitening), .crc_init_uap(crc_init_uap),
        .fhs_capture(fhs_capture), .py_period(py_period), .rxpy_bit(rxpy_bit),
        .rxpy_valid_p(rxpy_valid_p), .rxpy_bitcount(rxpy_bitcount), .py_endp(py_endp),
        .crc_ok(crc_ok), .fec_corr_cnt(fec_corr_cnt), .fec_uncorr(fec_uncorr),
        .fhs_data(fhs_data)
    );

    int           n_cmp = 0;
    int           n_bad = 0;
    bit           got_q[$];
    int           flip_q[$];
    int           idx_bad = 0;
    int           endp_cnt = 0;
    int           per_bad = 0;
    logic         crc_at_endp = 1'b0;
    logic [143:0] fhs_exp = '0;

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pmod(input int v);
        int r;
        r = v;
        for (int i = 14; i >= 5; i--) if (((r >> i) & 1) != 0) r = r ^ (53 << (i - 5));
        return r & 31;
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] c, input bit b);
        return (c << 1) ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    function automatic logic [6:0] wh_step(input logic [6:0] s);
        return {s[5:4], s[3] ^ s[6], s[2:0], s[6]};
    endfunction

    always @(negedge clk_6M) begin
        if (rxpy_valid_p) begin
            if (int'(rxpy_bitcount) != got_q.size()) idx_bad++;
            got_q.push_back(rxpy_bit);
        end
        if (py_endp) begin
            endp_cnt++;
            crc_at_endp = crc_ok;
            if (!py_period) per_bad++;
        end
    end

    // n_drive >= 0 sends only that many coded bits and returns without checking.
    task automatic run_packet(input string nm, input int pylen, input bit crcen, input bit fecen,
                              input bit fhs, input int n_rand, input int n_drive);
        bit msg[$];
        bit code[$];
        bit dec[$];
        bit txb[$];
        logic [15:0] c;
        logic [6:0]  ws;
        logic [6:0]  seed7;
        logic [7:0]  uap;
        int L, nblk, w, nd, mm, exp_corr, found, lat_bad;
        bit exp_unc, exp_ok;
        seed7 = 7'($urandom_range(0, 127));
        uap   = 8'($urandom_range(0, 255));
        for (int k = 0; k < pylen; k++) msg.push_back(1'($urandom_range(0, 1)));
        if (crcen) begin
            c = {8'h00, uap};
            for (int k = 0; k < pylen; k++) c = crc_step(c, msg[k]);
            for (int i = 0; i < 16; i++) msg.push_back(c[15-i]);
        end
        L = msg.size();
        nblk = (L + 9) / 10;
        if (fecen) begin
            for (int b = 0; b < nblk; b++) begin
                w = 0;
                for (int j = 0; j < 10; j++)
                    if (b * 10 + j < L && msg[b*10+j]) w = w | (1 << (14 - j));
                w = w | pmod(w);
                for (int i = 14; i >= 0; i--) code.push_back(1'((w >> i) & 1));
            end
        end else begin
            foreach (msg[i]) code.push_back(msg[i]);
        end
        repeat (n_rand) flip_q.push_back($urandom_range(0, code.size() - 1));
        foreach (flip_q[i]) code[flip_q[i]] = ~code[flip_q[i]];
        flip_q.delete();
        ws = seed7;
        foreach (code[i]) begin
            txb.push_back(code[i] ^ ws[6]);
            ws = wh_step(ws);
        end
        exp_corr = 0;
        exp_unc  = 1'b0;
        if (fecen) begin
            for (int b = 0; b < nblk; b++) begin
                w = 0;
                for (int i = 0; i < 15; i++) if (code[b*15+i]) w = w | (1 << (14 - i));
                if (pmod(w) != 0) begin
                    found = -1;
                    for (int p = 0; p < 15; p++) if (pmod(w ^ (1 << p)) == 0) found = p;
                    if (found >= 0) begin
                        w = w ^ (1 << found);
                        exp_corr++;
                    end else begin
                        exp_unc = 1'b1;
                    end
                end
                for (int j = 0; j < 10; j++) dec.push_back(1'((w >> (14 - j)) & 1));
            end
        end else begin
            foreach (code[i]) dec.push_back(code[i]);
        end
        exp_ok = 1'b1;
        if (crcen) begin
            c = {8'h00, uap};
            for (int k = 0; k < pylen; k++) c = crc_step(c, dec[k]);
            for (int i = 0; i < 16; i++) if (dec[pylen+i] != c[15-i]) exp_ok = 1'b0;
        end

        @(posedge clk_6M); #1;
        pylenbit     = LEN_W'(pylen);
        crcencode    = crcen;
        fec32encode  = fecen;
        fhs_capture  = fhs;
        whitening    = seed7;
        crc_init_uap = uap;
        py_st_p      = 1'b1;
        got_q.delete();
        endp_cnt = 0;
        idx_bad  = 0;
        per_bad  = 0;
        @(posedge clk_6M); #1;
        py_st_p = 1'b0;
        lat_bad = 0;
        nd = (n_drive < 0) ? txb.size() : n_drive;
        for (int i = 0; i < nd; i++) begin
            repeat ($urandom_range(5, 7)) @(posedge clk_6M);
            #1;
            rxbit = txb[i];
            rxbit_valid_p = 1'b1;
            @(posedge clk_6M); #1;
            rxbit_valid_p = 1'b0;
            if (!fecen) begin
                if (i < pylen) begin
                    if (!(rxpy_valid_p === 1'b1 && rxpy_bit === dec[i])) lat_bad++;
                end else if (rxpy_valid_p !== 1'b0) begin
                    lat_bad++;
                end
            end
        end
        if (n_drive >= 0) return;
        for (int t = 0; t < 300 && endp_cnt == 0; t++) @(posedge clk_6M);
        repeat (5) @(posedge clk_6M);
        #1;
        mm = 0;
        for (int k = 0; k < pylen && k < got_q.size(); k++) if (got_q[k] != dec[k]) mm++;
        check({nm, ".nvalid"}, 144'(got_q.size()), 144'(pylen));
        check({nm, ".data"}, 144'(mm), 144'(0));
        check({nm, ".bitcount"}, 144'(idx_bad), 144'(0));
        check({nm, ".endp"}, 144'(endp_cnt), 144'(1));
        check({nm, ".period_at_endp"}, 144'(per_bad), 144'(0));
        check({nm, ".period_after"}, 144'(py_period), 144'(0));
        check({nm, ".crc_ok"}, 144'(crc_at_endp), 144'(exp_ok));
        check({nm, ".corr_cnt"}, 144'(fec_corr_cnt), 144'(exp_corr));
        check({nm, ".uncorr"}, 144'(fec_uncorr), 144'(exp_unc));
        if (!fecen) check({nm, ".latency1"}, 144'(lat_bad), 144'(0));
        if (fhs) begin
            for (int k = 0; k < pylen && k < 144; k++) fhs_exp[k] = dec[k];
        end
        check({nm, ".fhs_data"}, fhs_data, fhs_exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hi;
        repeat (3) @(posedge clk_6M);
        #1;
        check("rst.py_period", 144'(py_period), 144'(0));
        check("rst.valid", 144'(rxpy_valid_p), 144'(0));
        check("rst.endp", 144'(py_endp), 144'(0));
        check("rst.crc_ok", 144'(crc_ok), 144'(0));
        check("rst.corr", 144'(fec_corr_cnt), 144'(0));
        check("rst.fhs", fhs_data, 144'(0));
        rst = 1'b0;

        run_packet("fhs_clean", 144, 1, 1, 1, 0, -1);
        flip_q = '{3, 117, 239};
        run_packet("fhs_fix3", 144, 1, 1, 1, 0, -1);
        flip_q = '{62, 68};
        run_packet("fhs_dbl", 144, 1, 1, 1, 0, -1);
        run_packet("nofec8", 8, 1, 0, 0, 0, -1);
        flip_q = '{11};
        run_packet("nofec8_crcerr", 8, 1, 0, 0, 0, -1);

        @(posedge clk_6M); #1;
        pylenbit = '0;
        py_st_p  = 1'b1;
        endp_cnt = 0;
        @(posedge clk_6M); #1;
        py_st_p = 1'b0;
        hi = 0;
        repeat (20) begin
            @(posedge clk_6M); #1;
            if (py_period) hi++;
        end
        check("len0.period", 144'(hi), 144'(0));
        check("len0.endp", 144'(endp_cnt), 144'(0));

        run_packet("len5_fec", 5, 0, 1, 0, 0, -1);

        flip_q = '{2};
        run_packet("abort_part", 200, 1, 1, 0, 0, 100);
        run_packet("after_abort", 120, 1, 1, 0, 0, -1);

        for (int r = 0; r < 6; r++) begin
            run_packet($sformatf("rand%0d", r), $urandom_range(1, 200), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2), -1);
        end

        flip_q = '{4};
        run_packet("rst_part", 150, 1, 1, 1, 0, 40);
        @(posedge clk_6M); #1;
        rst = 1'b1;
        @(posedge clk_6M); #1;
        fhs_exp = '0;
        check("midrst.period", 144'(py_period), 144'(0));
        check("midrst.corr", 144'(fec_corr_cnt), 144'(0));
        check("midrst.bitcount", 144'(rxpy_bitcount), 144'(0));
        check("midrst.fhs", fhs_data, fhs_exp);
        check("midrst.uncorr_crc", 144'({fec_uncorr, crc_ok, rxpy_valid_p, py_endp}), 144'(0));
        rst = 1'b0;
        run_packet("post_rst", 30, 1, 1, 1, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
